iram_load_ctrl: RTL and testbench

- Sequencer for the 512x9 CoreABC instruction RAM.
- Accepts a 9-bit word stream over a valid/ready handshake and writes it through the RAM init port (INITADDR/INITDATA/WENABLE).
- Optionally reads the whole image back through the read port and checks it against a running checksum.
- Then grants the read port to the instruction-fetch requester.
- Sits between the RAM wrapper and both the boot/programming source and the CoreABC fetch logic.

---
 rtl/iram_load_ctrl_if.sv | 34 +++
 rtl/iram_load_ctrl.sv | 145 ++++++++++++++
 tb/tb_iram_load_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iram_load_ctrl_if.sv
// Signal bundle between the instruction-RAM load sequencer, its stream/fetch clients and the RAM.
// The slave modport is the sequencer's view; the master modport is the surrounding environment's.
interface iram_load_ctrl_if;
   logic        START;
   logic [8:0]  S_DATA;
   logic        S_VALID;
   logic        S_READY;
   logic        FETCH_EN;
   logic [8:0]  FETCH_ADDR;
   logic [8:0]  FETCH_DATA;
   logic        FETCH_VALID;
   logic        RAM_RENABLE;
   logic [8:0]  RAM_RADDR;
   logic [8:0]  RAM_RD;
   logic        RAM_WENABLE;
   logic [8:0]  RAM_INITADDR;
   logic [8:0]  RAM_INITDATA;
   logic        BUSY;
   logic        DONE;
   logic        ERROR;
   logic [15:0] CHECKSUM;

   modport slave (
      input  START, S_DATA, S_VALID, FETCH_EN, FETCH_ADDR, RAM_RD,
      output S_READY, FETCH_DATA, FETCH_VALID, RAM_RENABLE, RAM_RADDR, RAM_WENABLE,
             RAM_INITADDR, RAM_INITDATA, BUSY, DONE, ERROR, CHECKSUM
   );

   modport master (
      output START, S_DATA, S_VALID, FETCH_EN, FETCH_ADDR, RAM_RD,
      input  S_READY, FETCH_DATA, FETCH_VALID, RAM_RENABLE, RAM_RADDR, RAM_WENABLE,
             RAM_INITADDR, RAM_INITDATA, BUSY, DONE, ERROR, CHECKSUM
   );
endinterface

// File: rtl/iram_load_ctrl.sv
// Loads a 9-bit word stream into the CoreABC instruction RAM, optionally verifies it by
// checksum readback, then hands the RAM read port to instruction fetch.
module iram_load_ctrl #(
   parameter int unsigned WORDS  = 512,
   parameter bit          VERIFY = 1'b1
) (
   input logic              RWCLK,
   input logic              RESET,
   iram_load_ctrl_if.slave  bus
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StLoad   = 3'd1;
   localparam logic [2:0] StVerify = 3'd2;
   localparam logic [2:0] StRun    = 3'd3;
   localparam logic [2:0] StError  = 3'd4;

   localparam logic [8:0] LastAddr  = 9'(WORDS - 1);
   localparam logic [9:0] NumWords  = 10'(WORDS);
   localparam logic [9:0] VerifyEnd = 10'(WORDS + 1);

   logic [2:0]  state_q, state_d;
   logic [8:0]  cnt_q, cnt_d;
   logic        last_q, last_d;
   logic [15:0] csum_q, csum_d;
   logic [9:0]  vcnt_q, vcnt_d;
   logic [15:0] vsum_q, vsum_d;
   logic        rdv_q, rdv_d;
   logic        wen_q, wen_d;
   logic [8:0]  waddr_q, waddr_d;
   logic [8:0]  wdata_q, wdata_d;
   logic        fvalid_q, fvalid_d;
   logic [8:0]  fdata_q, fdata_d;
   logic        accept;

   // last_q marks the drain cycle after the final word, so its write never meets a read.
   assign accept = (state_q == StLoad) && !last_q && bus.S_VALID;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      csum_d   = csum_q;
      vcnt_d   = vcnt_q;
      vsum_d   = vsum_q;
      rdv_d    = 1'b0;
      wen_d    = accept;
      waddr_d  = accept ? cnt_q : waddr_q;
      wdata_d  = accept ? bus.S_DATA : wdata_q;
      fvalid_d = (state_q == StRun) && bus.FETCH_EN;
      fdata_d  = fvalid_q ? bus.RAM_RD : fdata_q;

      case (state_q)
         StIdle, StRun, StError: begin
            if (bus.START) begin
               state_d = StLoad;
               cnt_d   = '0;
               csum_d  = '0;
               last_d  = 1'b0;
            end
         end
         StLoad: begin
            if (accept) begin
               csum_d = csum_q + {7'b0, bus.S_DATA};
               if (cnt_q == LastAddr) begin
                  last_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 9'd1;
               end
            end
            if (last_q) begin
               state_d = VERIFY ? StVerify : StRun;
               last_d  = 1'b0;
               vcnt_d  = '0;
               vsum_d  = '0;
            end
         end
         StVerify: begin
            vcnt_d = vcnt_q + 10'd1;
            rdv_d  = vcnt_q < NumWords;
            if (rdv_q) begin
               vsum_d = vsum_q + {7'b0, bus.RAM_RD};
            end
            if (vcnt_q == VerifyEnd) begin
               state_d = (vsum_q == csum_q) ? StRun : StError;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge RWCLK) begin
      if (RESET) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         last_q   <= 1'b0;
         csum_q   <= '0;
         vcnt_q   <= '0;
         vsum_q   <= '0;
         rdv_q    <= 1'b0;
         wen_q    <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         fvalid_q <= 1'b0;
         fdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         csum_q   <= csum_d;
         vcnt_q   <= vcnt_d;
         vsum_q   <= vsum_d;
         rdv_q    <= rdv_d;
         wen_q    <= wen_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         fvalid_q <= fvalid_d;
         fdata_q  <= fdata_d;
      end
   end

   always_comb begin
      bus.RAM_RENABLE = 1'b0;
      bus.RAM_RADDR   = '0;
      if (state_q == StVerify) begin
         bus.RAM_RENABLE = vcnt_q < NumWords;
         bus.RAM_RADDR   = vcnt_q[8:0];
      end else if (state_q == StRun) begin
         bus.RAM_RENABLE = bus.FETCH_EN;
         bus.RAM_RADDR   = bus.FETCH_ADDR;
      end
   end

   assign bus.S_READY      = (state_q == StLoad) && !last_q;
   assign bus.RAM_WENABLE  = wen_q;
   assign bus.RAM_INITADDR = waddr_q;
   assign bus.RAM_INITDATA = wdata_q;
   assign bus.FETCH_VALID  = fvalid_q;
   assign bus.FETCH_DATA   = fvalid_q ? bus.RAM_RD : fdata_q;
   assign bus.BUSY         = (state_q == StLoad) || (state_q == StVerify);
   assign bus.DONE         = state_q == StRun;
   assign bus.ERROR        = state_q == StError;
   assign bus.CHECKSUM     = csum_q;

endmodule

// File: tb/tb_iram_load_ctrl.sv
// Directed bench for iram_load_ctrl: full 512-word loads with verify, error injection,
// fetch, mid-load reset, and a 16-word no-verify instance.
module tb_iram_load_ctrl;

   logic RWCLK = 1'b0;
   logic RESET;
   always #5 RWCLK = ~RWCLK;

   iram_load_ctrl_if bus_a ();
   iram_load_ctrl_if bus_b ();

   iram_load_ctrl #(.WORDS(512), .VERIFY(1'b1)) dut_a (
      .RWCLK (RWCLK),
      .RESET (RESET),
      .bus   (bus_a)
   );

   iram_load_ctrl #(.WORDS(16), .VERIFY(1'b0)) dut_b (
      .RWCLK (RWCLK),
      .RESET (RESET),
      .bus   (bus_b)
   );

   // RAM models: registered read, optional bit-0 corruption at address 100 on A.
   logic [8:0] mem_a [512];
   logic [8:0] mem_b [512];
   logic [8:0] rd_a, rd_b;
   logic       inject = 1'b0;

   always @(posedge RWCLK) begin
      if (bus_a.RAM_WENABLE) mem_a[bus_a.RAM_INITADDR] <= bus_a.RAM_INITDATA;
      if (bus_a.RAM_RENABLE)
         rd_a <= mem_a[bus_a.RAM_RADDR] ^ {8'd0, inject && (bus_a.RAM_RADDR == 9'd100)};
      if (bus_b.RAM_WENABLE) mem_b[bus_b.RAM_INITADDR] <= bus_b.RAM_INITDATA;
      if (bus_b.RAM_RENABLE) rd_b <= mem_b[bus_b.RAM_RADDR];
   end
   assign bus_a.RAM_RD = rd_a;
   assign bus_b.RAM_RD = rd_b;

   // Write log and port-conflict monitors.
   logic [8:0] wlog_addr [4096];
   logic [8:0] wlog_data [4096];
   int wcount = 0, wcount_b = 0, ren_b_pre = 0, overlap = 0;

   always @(posedge RWCLK) begin
      if (bus_a.RAM_WENABLE && wcount < 4096) begin
         wlog_addr[wcount] <= bus_a.RAM_INITADDR;
         wlog_data[wcount] <= bus_a.RAM_INITDATA;
         wcount <= wcount + 1;
      end
      if (bus_b.RAM_WENABLE) wcount_b <= wcount_b + 1;
      if (bus_b.RAM_RENABLE && !bus_b.DONE) ren_b_pre <= ren_b_pre + 1;
      if ((bus_a.RAM_WENABLE && bus_a.RAM_RENABLE) || (bus_b.RAM_WENABLE && bus_b.RAM_RENABLE))
         overlap <= overlap + 1;
   end

   int tests = 0, fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Streams n words k = 0..n-1 into A; start_at pulses START mid-load (ignored there).
   task automatic load_a(input int n, input bit toggle, input int start_at);
      int k = 0;
      int c = 0;
      while (k < n && c < 4000) begin
         bus_a.S_DATA  = 9'(k);
         bus_a.S_VALID = toggle ? ~c[0] : 1'b1;
         bus_a.START   = (c == start_at);
         if (bus_a.S_READY && bus_a.S_VALID) k++;
         c++;
         @(negedge RWCLK);
      end
      bus_a.S_VALID = 1'b0;
      bus_a.START   = 1'b0;
      chk("stream_words", 32'(k), 32'(n));
   endtask

   task automatic start_a();
      bus_a.START   = 1'b1;
      bus_a.S_VALID = 1'b1;
      bus_a.S_DATA  = 9'h155;
      @(negedge RWCLK);
      bus_a.START   = 1'b0;
      bus_a.S_VALID = 1'b0;
      chk("start_busy", 32'(bus_a.BUSY), 32'd1);
      chk("start_no_accept", 32'(bus_a.RAM_WENABLE), 32'd0);
      chk("start_csum_clr", 32'(bus_a.CHECKSUM), 32'd0);
   endtask

   task automatic wait_busy_a(output int b);
      b = 0;
      while (bus_a.BUSY && b < 2000) begin
         b++;
         @(negedge RWCLK);
      end
   endtask

   task automatic chk_writes(input int base, input int n);
      int err = 0;
      for (int i = 0; i < n; i++)
         if (wlog_addr[base + i] !== 9'(i) || wlog_data[base + i] !== 9'(i)) err++;
      chk("write_count", 32'(wcount - base), 32'(n));
      chk("write_seq", 32'(err), 32'd0);
   endtask

   initial begin
      int b, base, wc, c;
      RESET = 1'b1;
      bus_a.START = 1'b0; bus_a.S_DATA = '0; bus_a.S_VALID = 1'b0;
      bus_a.FETCH_EN = 1'b0; bus_a.FETCH_ADDR = '0;
      bus_b.START = 1'b0; bus_b.S_DATA = '0; bus_b.S_VALID = 1'b0;
      bus_b.FETCH_EN = 1'b0; bus_b.FETCH_ADDR = '0;
      repeat (2) @(negedge RWCLK);
      chk("rst_outputs", {bus_a.S_READY, bus_a.FETCH_VALID, bus_a.RAM_RENABLE, bus_a.RAM_WENABLE,
                          bus_a.BUSY, bus_a.DONE, bus_a.ERROR}, 32'd0);
      chk("rst_csum", 32'(bus_a.CHECKSUM), 32'd0);
      chk("rst_fdata", 32'(bus_a.FETCH_DATA), 32'd0);
      chk("rst_addrs", {bus_a.RAM_INITADDR, bus_a.RAM_INITDATA, bus_a.RAM_RADDR}, 32'd0);
      RESET = 1'b0;
      @(negedge RWCLK);

      // Instance B: 16 words, no verify.
      bus_b.START = 1'b1;
      @(negedge RWCLK);
      bus_b.START = 1'b0;
      c = 0; b = 0;
      while (b < 16 && c < 100) begin
         bus_b.S_DATA = 9'(b); bus_b.S_VALID = 1'b1;
         if (bus_b.S_READY) b++;
         c++;
         @(negedge RWCLK);
      end
      bus_b.S_VALID = 1'b0;
      chk("b_drain_done", 32'(bus_b.DONE), 32'd0);
      chk("b_drain_ready", 32'(bus_b.S_READY), 32'd0);
      @(negedge RWCLK);
      chk("b_run", 32'(bus_b.DONE), 32'd1);
      chk("b_csum", 32'(bus_b.CHECKSUM), 32'h78);
      chk("b_writes", 32'(wcount_b), 32'd16);
      chk("b_no_ren", 32'(ren_b_pre), 32'd0);

      // A: full load, S_VALID held.
      base = wcount;
      start_a();
      load_a(512, 1'b0, -1);
      chk("ready_drop", 32'(bus_a.S_READY), 32'd0);
      wait_busy_a(b);
      chk("busy_cycles", 32'(b), 32'd515);
      chk("done", 32'(bus_a.DONE), 32'd1);
      chk("csum", 32'(bus_a.CHECKSUM), 32'hFF00);
      chk_writes(base, 512);

      // A: toggling S_VALID with a stray START mid-load.
      base = wcount;
      start_a();
      load_a(512, 1'b1, 50);
      wait_busy_a(b);
      chk("tog_busy_cycles", 32'(b), 32'd515);
      chk("tog_done", 32'(bus_a.DONE), 32'd1);
      chk("tog_csum", 32'(bus_a.CHECKSUM), 32'hFF00);
      chk_writes(base, 512);

      // Fetch 5,6,7 back-to-back.
      chk("fv_idle", 32'(bus_a.FETCH_VALID), 32'd0);
      bus_a.FETCH_EN = 1'b1; bus_a.FETCH_ADDR = 9'd5;
      #1;
      chk("f_ren_pass", {bus_a.RAM_RENABLE, bus_a.RAM_RADDR}, 32'h205);
      @(negedge RWCLK);
      chk("f5", {bus_a.FETCH_VALID, bus_a.FETCH_DATA}, 32'h205);
      bus_a.FETCH_ADDR = 9'd6;
      @(negedge RWCLK);
      chk("f6", {bus_a.FETCH_VALID, bus_a.FETCH_DATA}, 32'h206);
      bus_a.FETCH_ADDR = 9'd7;
      @(negedge RWCLK);
      chk("f7", {bus_a.FETCH_VALID, bus_a.FETCH_DATA}, 32'h207);
      bus_a.FETCH_EN = 1'b0;
      @(negedge RWCLK);
      chk("f_hold", {bus_a.FETCH_VALID, bus_a.FETCH_DATA}, 32'h007);

      // Restart from RUN with a fetch in flight, then corrupt readback.
      bus_a.START = 1'b1; bus_a.FETCH_EN = 1'b1; bus_a.FETCH_ADDR = 9'd9;
      @(negedge RWCLK);
      bus_a.START = 1'b0; bus_a.FETCH_EN = 1'b0;
      chk("inflight_fetch", {bus_a.FETCH_VALID, bus_a.FETCH_DATA}, 32'h209);
      chk("restart_state", {bus_a.BUSY, bus_a.DONE, bus_a.ERROR}, 32'h4);
      chk("restart_csum", 32'(bus_a.CHECKSUM), 32'd0);
      inject = 1'b1;
      load_a(512, 1'b0, -1);
      wait_busy_a(b);
      chk("err_flag", {bus_a.BUSY, bus_a.DONE, bus_a.ERROR}, 32'h1);
      chk("err_csum", 32'(bus_a.CHECKSUM), 32'hFF00);
      bus_a.FETCH_EN = 1'b1; bus_a.FETCH_ADDR = 9'd3;
      #1;
      chk("err_no_ren", 32'(bus_a.RAM_RENABLE), 32'd0);
      @(negedge RWCLK);
      bus_a.FETCH_EN = 1'b0;
      chk("err_no_fv", 32'(bus_a.FETCH_VALID), 32'd0);
      chk("err_held", 32'(bus_a.ERROR), 32'd1);
      inject = 1'b0;
      bus_a.START = 1'b1;
      @(negedge RWCLK);
      bus_a.START = 1'b0;
      chk("err_restart", {bus_a.BUSY, bus_a.DONE, bus_a.ERROR}, 32'h4);
      chk("err_restart_csum", 32'(bus_a.CHECKSUM), 32'd0);

      // Reset after 200 accepted words.
      base = wcount;
      load_a(200, 1'b0, -1);
      chk("pre_rst_wen", 32'(bus_a.RAM_WENABLE), 32'd1);
      RESET = 1'b1; bus_a.S_VALID = 1'b1;
      @(negedge RWCLK);
      chk("mid_rst_out", {bus_a.S_READY, bus_a.RAM_WENABLE, bus_a.RAM_RENABLE, bus_a.BUSY,
                          bus_a.DONE, bus_a.ERROR, bus_a.FETCH_VALID}, 32'd0);
      chk("mid_rst_csum", 32'(bus_a.CHECKSUM), 32'd0);
      chk_writes(base, 200);
      wc = wcount;
      RESET = 1'b0;
      repeat (3) @(negedge RWCLK);
      bus_a.S_VALID = 1'b0;
      chk("idle_no_write", 32'(wcount), 32'(wc));
      base = wcount;
      start_a();
      load_a(512, 1'b0, -1);
      wait_busy_a(b);
      chk("rerun_done", 32'(bus_a.DONE), 32'd1);
      chk("rerun_csum", 32'(bus_a.CHECKSUM), 32'hFF00);
      chk_writes(base, 512);
      chk("no_overlap", 32'(overlap), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
